fetch_target_queue: RTL and testbench
=====================================

// Module: fetch_target_queue
// PURPOSE
//  Fetch target queue (FTQ) between the branch predictor and the decode/backend read side.
//  It buffers one predicted fetch block per entry: start PC, target PC, taken flag and instruction count.
//  It is the requester side of the frontend stall/flush protocol:
//   - raises FTQReq toward the frontend Ctrl when nearly full;
//   - obeys FTQStop (gate enqueue) and FTQFlash (ROB redirect, clear queue) from Ctrl.
// PARAMETERS
//  DEPTH   16  number of entries; power of 2, >=4
//  PC_W    32  PC width
//  NUM_W   3   width of the per-block instruction count
//  SKID    2   headroom; FTQReq asserts when Count >= DEPTH-SKID
// PORTS
//  Clk          in   1        clock; all state updates on posedge
//  Rest         in   1        synchronous reset, active-high
//  FTQStop      in   1        from Ctrl; 1 = refuse enqueue this cycle
//  FTQFlash     in   1        from Ctrl (ROB redirect); 1 = discard all entries
//  EnqValid     in   1        predictor offers a block
//  EnqStartPc   in   PC_W     block start PC
//  EnqTargetPc  in   PC_W     predicted next-block PC
//  EnqTaken     in   1        block ends in a predicted-taken branch
//  EnqInstNum   in   NUM_W    valid instructions in block
//  EnqReady     out  1        enqueue accepted this cycle if EnqValid
//  DeqReady     in   1        consumer takes head entry
//  DeqValid     out  1        head entry valid
//  DeqStartPc   out  PC_W     head start PC
//  DeqTargetPc  out  PC_W     head target PC
//  DeqTaken     out  1        head taken flag
//  DeqInstNum   out  NUM_W    head instruction count
//  FTQReq       out  1        to Ctrl; queue nearly full
//  Count        out  log2(DEPTH)+1  occupancy
//  FtqOvf       out  1        sticky error: EnqValid & ~FTQStop while full
// BEHAVIOUR
//  Reset (Rest=1 at posedge):
//   - head=tail=0, Count=0, FtqOvf=0.
//   - Hence DeqValid=0, FTQReq=0, EnqReady=1 in the following cycle.
//   - Entry storage is not reset.
//  Handshake:
//   - EnqReady = ~FTQStop & (Count!=DEPTH) & ~FTQFlash; enq fires = EnqValid & EnqReady.
//   - DeqValid = (Count!=0); deq fires = DeqValid & DeqReady & ~FTQFlash.
//   - Head data is first-word-fall-through: combinational read of entry[head], zero added latency.
//   - Enqueued entry is visible at Deq* the cycle after enq fires; no same-cycle bypass when empty.
//  Pointers:
//   - head/tail are log2(DEPTH) bits and wrap modulo DEPTH.
//   - Count += enq - deq; simultaneous enq+deq leaves Count unchanged.
//   - Enq while full is blocked even if deq fires the same cycle.
//  FTQReq:
//   - Combinational from registered Count only: Count >= DEPTH-SKID.
//   - Ctrl returns it as FTQStop the same cycle; there is no loop because FTQReq never depends on FTQStop.
//  FTQStop from other sources (IcReq/BpReq): enqueue is blocked; dequeue continues normally.
//  FTQFlash:
//   - Highest priority below Rest: next cycle head=tail=0, Count=0.
//   - Any enq/deq in the flash cycle is ignored (EnqReady=0, deq does not count).
//   - FtqOvf is not cleared by flash.
//  FtqOvf:
//   - Set when EnqValid & ~FTQStop & ~FTQFlash & Count==DEPTH; data is dropped.
//   - Cleared only by Rest.
//  Reset mid-operation: Rest overrides flash/enq/deq; the queue empties within one cycle.
// STRUCTURE
//  - Shared package (frontend defines): FTQ_DEPTH, FTQ_PTR_W, PC_W, FTQ entry field widths and packing order.
//  - Sub-module ftq_entry_ram: DEPTH x (2*PC_W+1+NUM_W) regfile, one write port (tail), one async read port (head).
//  - Top holds pointers, Count, handshake and FTQReq/FtqOvf logic.
// TESTING
//  1. Reset, then 3 enq (PC 0x1000,0x1010,0x1020), DeqReady=0 -> Count=3, DeqStartPc=0x1000, FTQReq=0.
//  2. Fill with DeqReady=0, DEPTH=16, SKID=2 -> FTQReq=1 from Count=14; with FTQStop tied to FTQReq, Count holds 14; FtqOvf=0.
//  3. Count=16 with FTQStop forced 0, EnqValid=1 -> EnqReady=0, FtqOvf=1, Count stays 16; DeqReady=1 same cycle -> Count=15 next.
//  4. 40 enq/deq pairs at Count=5 -> Count stays 5, pointers wrap, Deq order equals enq order.
//  5. Count=9, EnqValid=1 and DeqReady=1 with FTQFlash=1 -> next cycle Count=0, DeqValid=0, FTQReq=0.
//  6. Empty, enq 0x2000 with DeqReady=1 -> DeqValid=0 that cycle, 1 the next, with DeqStartPc=0x2000.

Source files
------------

// File: rtl/fetch_target_queue_pkg.sv
// rtl/fetch_target_queue_pkg.sv - frontend defines shared by the fetch target queue and its entry storage
package fetch_target_queue_pkg;

    localparam int FTQ_DEPTH = 16;
    localparam int FTQ_PTR_W = $clog2(FTQ_DEPTH);
    localparam int FTQ_CNT_W = FTQ_PTR_W + 1;
    localparam int FTQ_PC_W  = 32;
    localparam int FTQ_NUM_W = 3;
    localparam int FTQ_SKID  = 2;

    // Entry packing, MSB first: {startPc, targetPc, taken, instNum}
    localparam int FTQ_ENTRY_W    = 2 * FTQ_PC_W + 1 + FTQ_NUM_W;
    localparam int FTQ_NUM_LSB    = 0;
    localparam int FTQ_TAKEN_LSB  = FTQ_NUM_LSB + FTQ_NUM_W;
    localparam int FTQ_TARGET_LSB = FTQ_TAKEN_LSB + 1;
    localparam int FTQ_START_LSB  = FTQ_TARGET_LSB + FTQ_PC_W;

endpackage

// File: rtl/ftq_entry_ram.sv
// rtl/ftq_entry_ram.sv - fetch target queue entry regfile, one write port and one async read port
module ftq_entry_ram
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH,
    parameter int WIDTH = FTQ_ENTRY_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic [AW-1:0]    RdAddr,
    output logic [WIDTH-1:0] RdData
);

    // Storage is intentionally not reset; validity is tracked by the pointers.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
    end

    assign RdData = mem[RdAddr];

endmodule

// File: rtl/fetch_target_queue.sv
// rtl/fetch_target_queue.sv - fetch target queue between branch predictor and decode, with stall/flush handshake
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH,
    parameter int PC_W  = FTQ_PC_W,
    parameter int NUM_W = FTQ_NUM_W,
    parameter int SKID  = FTQ_SKID
) (
    input  logic                       Clk,
    input  logic                       Rest,
    input  logic                       FTQStop,
    input  logic                       FTQFlash,
    input  logic                       EnqValid,
    input  logic [PC_W-1:0]            EnqStartPc,
    input  logic [PC_W-1:0]            EnqTargetPc,
    input  logic                       EnqTaken,
    input  logic [NUM_W-1:0]           EnqInstNum,
    output logic                       EnqReady,
    input  logic                       DeqReady,
    output logic                       DeqValid,
    output logic [PC_W-1:0]            DeqStartPc,
    output logic [PC_W-1:0]            DeqTargetPc,
    output logic                       DeqTaken,
    output logic [NUM_W-1:0]           DeqInstNum,
    output logic                       FTQReq,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       FtqOvf
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * PC_W + 1 + NUM_W;

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   occupancy;
    logic               ovfFlag;
    logic               full;
    logic               enqFire;
    logic               deqFire;
    logic               ovfEvent;
    logic [ENTRY_W-1:0] enqEntry;
    logic [ENTRY_W-1:0] headEntry;

    assign full     = (occupancy == CNT_W'(DEPTH));
    assign EnqReady = ~FTQStop & ~full & ~FTQFlash;
    assign DeqValid = (occupancy != '0);
    assign enqFire  = EnqValid & EnqReady;
    assign deqFire  = DeqValid & DeqReady & ~FTQFlash;
    assign ovfEvent = EnqValid & ~FTQStop & ~FTQFlash & full;

    // Only registered occupancy feeds FTQReq, so Ctrl can loop it back as FTQStop combinationally.
    assign FTQReq = (occupancy >= CNT_W'(DEPTH - SKID));
    assign Count  = occupancy;
    assign FtqOvf = ovfFlag;

    always_ff @(posedge Clk) begin
        if (Rest) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (FTQFlash) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (enqFire) begin
                tail <= tail + 1'b1;
            end
            if (deqFire) begin
                head <= head + 1'b1;
            end
            case ({enqFire, deqFire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Sticky: survives flashes so software can see the dropped block.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            ovfFlag <= 1'b0;
        end else if (ovfEvent) begin
            ovfFlag <= 1'b1;
        end
    end

    assign enqEntry = {EnqStartPc, EnqTargetPc, EnqTaken, EnqInstNum};

    ftq_entry_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_entryRam (
        .Clk    (Clk),
        .WrEn   (enqFire & ~Rest),
        .WrAddr (tail),
        .WrData (enqEntry),
        .RdAddr (head),
        .RdData (headEntry)
    );

    assign {DeqStartPc, DeqTargetPc, DeqTaken, DeqInstNum} = headEntry;

endmodule

// File: tb/tb_fetch_target_queue.sv
// tb/tb_fetch_target_queue.sv - randomized self-checking bench for fetch_target_queue against a queue model
module tb_fetch_target_queue;

    localparam int DEPTH = 16;
    localparam int SKID  = 2;
    localparam int PC_W  = 32;
    localparam int NUM_W = 3;

    logic             Clk = 1'b0;
    logic             Rest, FTQStop, FTQFlash, EnqValid, EnqTaken, DeqReady;
    logic [PC_W-1:0]  EnqStartPc, EnqTargetPc;
    logic [NUM_W-1:0] EnqInstNum;
    logic             EnqReady, DeqValid, DeqTaken, FTQReq, FtqOvf;
    logic [PC_W-1:0]  DeqStartPc, DeqTargetPc;
    logic [NUM_W-1:0] DeqInstNum;
    logic [4:0]       Count;

    typedef struct {
        logic [PC_W-1:0]  sp;
        logic [PC_W-1:0]  tp;
        logic             tk;
        logic [NUM_W-1:0] n;
    } ent_t;

    ent_t q[$];
    bit   mOvf;
    int   passed = 0;
    int   total  = 0;

    always #5 Clk = ~Clk;

    fetch_target_queue dut (
        .Clk(Clk), .Rest(Rest), .FTQStop(FTQStop), .FTQFlash(FTQFlash),
        .EnqValid(EnqValid), .EnqStartPc(EnqStartPc), .EnqTargetPc(EnqTargetPc),
        .EnqTaken(EnqTaken), .EnqInstNum(EnqInstNum), .EnqReady(EnqReady),
        .DeqReady(DeqReady), .DeqValid(DeqValid), .DeqStartPc(DeqStartPc),
        .DeqTargetPc(DeqTargetPc), .DeqTaken(DeqTaken), .DeqInstNum(DeqInstNum),
        .FTQReq(FTQReq), .Count(Count), .FtqOvf(FtqOvf)
    );

    task automatic drive(input bit ev, input logic [PC_W-1:0] sp, input logic [PC_W-1:0] tp,
                         input bit tk, input logic [NUM_W-1:0] n, input bit dr,
                         input bit stop, input bit flash);
        EnqValid = ev; EnqStartPc = sp; EnqTargetPc = tp; EnqTaken = tk; EnqInstNum = n;
        DeqReady = dr; FTQStop = stop; FTQFlash = flash;
        #1;
    endtask

    // Advance one clock and apply the queue rules to the model.
    task automatic step();
        bit   enqOk, deqOk, ovfHit;
        ent_t e;
        enqOk  = EnqValid && !FTQStop && !FTQFlash && (q.size() < DEPTH);
        deqOk  = (q.size() > 0) && DeqReady && !FTQFlash;
        ovfHit = EnqValid && !FTQStop && !FTQFlash && (q.size() == DEPTH);
        e.sp = EnqStartPc; e.tp = EnqTargetPc; e.tk = EnqTaken; e.n = EnqInstNum;
        @(posedge Clk);
        if (Rest) begin
            q.delete();
            mOvf = 0;
        end else if (FTQFlash) begin
            q.delete();
        end else begin
            if (ovfHit) mOvf = 1;
            if (deqOk) void'(q.pop_front());
            if (enqOk) q.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        Rest = 1'b1;
        drive(0, '0, '0, 0, '0, 0, 0, 0);
        step();
        Rest = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (Count !== 5'd0) $display("FAIL reset_count got %0d want 0", Count); else passed++;
        total++; if (DeqValid !== 1'b0) $display("FAIL reset_deqvalid got %b want 0", DeqValid); else passed++;
        total++; if (FTQReq !== 1'b0) $display("FAIL reset_ftqreq got %b want 0", FTQReq); else passed++;
        total++; if (EnqReady !== 1'b1) $display("FAIL reset_enqready got %b want 1", EnqReady); else passed++;
        total++; if (FtqOvf !== 1'b0) $display("FAIL reset_ovf got %b want 0", FtqOvf); else passed++;
    endtask

    task automatic test_basic_enq();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1000 + 32'(i * 16), 32'h1010 + 32'(i * 16), 0, 3'd4, 0, 0, 0);
            step();
        end
        drive(0, '0, '0, 0, '0, 0, 0, 0);
        total++; if (Count !== 5'd3) $display("FAIL basic_count got %0d want 3", Count); else passed++;
        total++; if (DeqStartPc !== 32'h1000) $display("FAIL basic_head got %h want 1000", DeqStartPc); else passed++;
        total++; if (FTQReq !== 1'b0) $display("FAIL basic_ftqreq got %b want 0", FTQReq); else passed++;
    endtask

    task automatic test_fill_stop();
        bit expReq;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            expReq = (q.size() >= DEPTH - SKID);
            drive(1, $urandom, $urandom, 1'($urandom), 3'($urandom), 0, expReq, 0);
            total++;
            if (FTQReq !== expReq) $display("FAIL fill_ftqreq cyc %0d got %b want %b", i, FTQReq, expReq);
            else passed++;
            step();
        end
        total++; if (Count !== 5'd14) $display("FAIL fill_count got %0d want 14", Count); else passed++;
        total++; if (FtqOvf !== 1'b0) $display("FAIL fill_ovf got %b want 0", FtqOvf); else passed++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom, $urandom, 1'($urandom), 3'($urandom), 0, 0, 0);
            step();
        end
        drive(1, 32'hdead0000, 32'hbeef0000, 1, 3'd7, 0, 0, 0);
        total++; if (Count !== 5'd16) $display("FAIL ovf_full got %0d want 16", Count); else passed++;
        total++; if (EnqReady !== 1'b0) $display("FAIL ovf_enqready got %b want 0", EnqReady); else passed++;
        step();
        total++; if (FtqOvf !== 1'b1) $display("FAIL ovf_flag got %b want 1", FtqOvf); else passed++;
        total++; if (Count !== 5'd16) $display("FAIL ovf_hold got %0d want 16", Count); else passed++;
        drive(1, 32'hdead0000, 32'hbeef0000, 1, 3'd7, 1, 0, 0);
        total++; if (EnqReady !== 1'b0) $display("FAIL ovf_enq_deq got %b want 0", EnqReady); else passed++;
        step();
        drive(0, '0, '0, 0, '0, 0, 0, 0);
        total++; if (Count !== 5'd15) $display("FAIL ovf_after_deq got %0d want 15", Count); else passed++;
        total++; if (DeqStartPc !== q[0].sp) $display("FAIL ovf_head got %h want %h", DeqStartPc, q[0].sp); else passed++;
    endtask

    task automatic test_flash();
        drive(1, $urandom, $urandom, 0, 3'd1, 1, 0, 1);
        step();
        drive(0, '0, '0, 0, '0, 0, 0, 0);
        total++; if (Count !== 5'd0) $display("FAIL flash1_count got %0d want 0", Count); else passed++;
        total++; if (FtqOvf !== 1'b1) $display("FAIL flash_keeps_ovf got %b want 1", FtqOvf); else passed++;
        for (int i = 0; i < 9; i++) begin
            drive(1, $urandom, $urandom, 1'($urandom), 3'($urandom), 0, 0, 0);
            step();
        end
        drive(1, 32'h5555, 32'h6666, 1, 3'd2, 1, 0, 1);
        total++; if (Count !== 5'd9) $display("FAIL flash_pre_count got %0d want 9", Count); else passed++;
        total++; if (EnqReady !== 1'b0) $display("FAIL flash_enqready got %b want 0", EnqReady); else passed++;
        step();
        drive(0, '0, '0, 0, '0, 0, 0, 0);
        total++; if (Count !== 5'd0) $display("FAIL flash_count got %0d want 0", Count); else passed++;
        total++; if (DeqValid !== 1'b0) $display("FAIL flash_deqvalid got %b want 0", DeqValid); else passed++;
        total++; if (FTQReq !== 1'b0) $display("FAIL flash_ftqreq got %b want 0", FTQReq); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, $urandom, $urandom, 1'($urandom), 3'($urandom), 0, 0, 0);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            drive(1, $urandom, $urandom, 1'($urandom), 3'($urandom), 1, 0, 0);
            total++;
            if (DeqValid !== 1'b1 || DeqStartPc !== q[0].sp || DeqTargetPc !== q[0].tp ||
                DeqTaken !== q[0].tk || DeqInstNum !== q[0].n)
                $display("FAIL wrap_order pair %0d got %h/%h/%b/%0d want %h/%h/%b/%0d", i,
                         DeqStartPc, DeqTargetPc, DeqTaken, DeqInstNum, q[0].sp, q[0].tp, q[0].tk, q[0].n);
            else passed++;
            step();
        end
        drive(0, '0, '0, 0, '0, 0, 0, 0);
        total++; if (Count !== 5'd5) $display("FAIL wrap_count got %0d want 5", Count); else passed++;
    endtask

    task automatic test_first_fall_through();
        do_reset();
        drive(1, 32'h2000, 32'h2040, 1, 3'd3, 1, 0, 0);
        total++; if (DeqValid !== 1'b0) $display("FAIL fwft_same_cycle got %b want 0", DeqValid); else passed++;
        step();
        drive(0, '0, '0, 0, '0, 0, 0, 0);
        total++; if (DeqValid !== 1'b1) $display("FAIL fwft_next got %b want 1", DeqValid); else passed++;
        total++; if (DeqStartPc !== 32'h2000) $display("FAIL fwft_pc got %h want 2000", DeqStartPc); else passed++;
    endtask

    task automatic test_random();
        bit stop, flash, rst, expReady;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flash = ($urandom_range(0, 99) < 3);
            stop  = ($urandom_range(0, 99) < 15);
            Rest  = rst;
            drive($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom), 3'($urandom),
                  $urandom_range(0, 1) == 1, stop, flash);
            expReady = !stop && !flash && (q.size() < DEPTH);
            total++;
            if (Count !== 5'(q.size()) || DeqValid !== (q.size() > 0) || EnqReady !== expReady ||
                FTQReq !== (q.size() >= DEPTH - SKID) || FtqOvf !== mOvf)
                $display("FAIL rand_ctrl cyc %0d cnt %0d/%0d dv %b er %b/%b req %b ovf %b/%b",
                         i, Count, q.size(), DeqValid, EnqReady, expReady, FTQReq, FtqOvf, mOvf);
            else passed++;
            if (q.size() > 0) begin
                total++;
                if (DeqStartPc !== q[0].sp || DeqTargetPc !== q[0].tp ||
                    DeqTaken !== q[0].tk || DeqInstNum !== q[0].n)
                    $display("FAIL rand_head cyc %0d got %h/%h want %h/%h", i,
                             DeqStartPc, DeqTargetPc, q[0].sp, q[0].tp);
                else passed++;
            end
            step();
        end
        Rest = 1'b0;
    endtask

    initial begin
        Rest = 1'b0;
        mOvf = 0;
        drive(0, '0, '0, 0, '0, 0, 0, 0);
        test_reset();
        test_basic_enq();
        test_fill_stop();
        test_overflow();
        test_flash();
        test_wrap();
        test_first_fall_through();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
